ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: the PC loaded on reset.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port imem_req, output, 1: instruction-memory read request.
REQ-005 SHALL have port imem_addr, output, 32: byte address of the fetch (current PC).
REQ-006 SHALL have port imem_ack, input, 1: memory has imem_rdata valid this cycle.
REQ-007 SHALL have port imem_rdata, input, 32: fetched instruction word.
REQ-008 SHALL have port instr_valid, output, 1: instr/op/func hold a valid instruction.
REQ-009 SHALL have port instr_ready, input, 1: downstream (decode/execute) consumes the instruction.
REQ-010 SHALL have port instr, output, 32: latched instruction.
REQ-011 SHALL have ports op and func, output, 6 each: instr[31:26] and instr[5:0], which feed the decoder.
REQ-012 SHALL have ports branch, jump and zero, input, 1 each: decoder Branch, decoder Jump and ALU zero, sampled only at consume.
REQ-013 SHALL have port pc, output, 32: address of the instruction in instr.

Function
REQ-014 SHALL implement FSM states FETCH and HOLD.
- FETCH: imem_req=1.
- HOLD: imem_req=0 and instr_valid=1.
REQ-015 In FETCH with imem_ack=1, SHALL latch imem_rdata into instr and go to HOLD; instr_valid SHALL rise the next cycle (1-cycle latency from ack).
REQ-016 In FETCH with imem_ack=0, SHALL stay in FETCH with imem_addr held stable for any number of wait cycles.
REQ-017 imem_ack while not in FETCH SHALL be ignored.
REQ-018 Consume SHALL be defined as HOLD with instr_ready=1. On consume, SHALL update the PC to npc and return to FETCH the next cycle.
REQ-019 While in HOLD with instr_ready=0, instr, pc, op and func SHALL hold their values.
REQ-020 npc SHALL be pc+4 by default.
REQ-021 If jump=1, npc SHALL be {pc_plus4[31:28], instr[25:0], 2'b00}; jump SHALL have priority over branch.
REQ-022 If branch=1, zero=1 and jump=0, npc SHALL be pc_plus4 + (sign-extended instr[15:0] << 2).
REQ-023 npc arithmetic SHALL be 32-bit modulo: PC 32'hFFFF_FFFC plus 4 wraps to 0, and branch offsets wrap likewise.
REQ-024 branch, jump and zero SHALL be ignored outside a consume cycle.
REQ-025 imem_addr SHALL equal pc at all times; the PC's low two bits SHALL always be 0.

Reset
REQ-026 rst=1 SHALL asynchronously force the following, regardless of any in-flight request or ack:
- state FETCH, pc=RESET_PC, instr=0;
- instr_valid=0, imem_req=0, retired_cnt=0.
REQ-027 imem_req SHALL first assert in the first cycle after rst deasserts.
REQ-028 An ack arriving in the same cycle rst is asserted SHALL be discarded.

Configuration
REQ-029 With macro IFETCH_RETIRE_CNT_EN defined:
- SHALL add output retired_cnt, 32 bits;
- retired_cnt SHALL increment by 1 per consume and wrap 32'hFFFF_FFFF to 0.
REQ-030 Without IFETCH_RETIRE_CNT_EN, the port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 Shared package cpu_pkg SHALL hold: the FSM state typedef, the default RESET_PC constant, and the opcode constants for beq (6'b000100) and j (6'b000010).
REQ-032 Next-PC computation SHALL be a combinational sub-module npc_calc, with inputs pc, instr, branch, jump and zero and output npc.

Verification
REQ-033 SHALL test reset, zero-wait fetch and consume:
- stimulus: release rst with RESET_PC=0; ack in the first FETCH cycle with rdata 32'h0000_0020; instr_ready=1.
- required: imem_addr=0; instr_valid high 1 cycle after ack; next imem_addr=4.
REQ-034 SHALL test wait states and backpressure:
- stimulus: ack delayed 3 cycles; instr_ready held 0 for 4 cycles.
- required: imem_addr stable throughout; instr and pc unchanged until consume.
REQ-035 SHALL test branch taken and not taken:
- stimulus: pc=32'h10, instr=32'h1000_FFFE, branch=1 at consume.
- required: with zero=1, npc=32'h0C; with zero=0, npc=32'h14.
REQ-036 SHALL test jump priority:
- stimulus: pc=32'h8000_0000, instr=32'h0800_0004, jump=1 and branch=1 with zero=1.
- required: npc=32'h8000_0010.
REQ-037 SHALL test wrap and reset mid-fetch:
- stimulus 1: pc=32'hFFFF_FFFC, default consume. Required: npc=0.
- stimulus 2: rst pulsed while waiting for ack, with a late ack. Required: ack ignored; pc=RESET_PC.
REQ-038 SHALL test the counter with IFETCH_RETIRE_CNT_EN:
- stimulus: 5 consumes.
- required: retired_cnt=5; retired_cnt returns to 0 on rst.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the instruction-fetch slice of the CPU.
//   fetchState_t      : fetch FSM state (FETCH waits on memory, HOLD offers
//                       the instruction downstream)
//   DEFAULT_RESET_PC  : default PC loaded on reset
//   OP_BEQ / OP_J     : primary opcodes of beq and j, for the decoder side
//   branchOffset()    : sign-extended, word-scaled branch displacement
// ---------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetchState_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    // A 16-bit word displacement becomes a 32-bit byte displacement.
    function automatic logic [31:0] branchOffset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/npc_calc.sv
// ---------------------------------------------------------------------------
// npc_calc
// Combinational next-PC selection for the fetch unit.
//   pc     in  32 : address of the instruction being retired
//   instr  in  32 : that instruction word (jump target / branch immediate)
//   branch in   1 : decoder Branch
//   jump   in   1 : decoder Jump (wins over branch)
//   zero   in   1 : ALU zero flag, qualifies a branch
//   npc    out 32 : address of the next instruction
// All arithmetic is 32-bit modulo, so the PC wraps naturally.
// ---------------------------------------------------------------------------
module npc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] npc
);

    logic [31:0] pcPlus4;

    assign pcPlus4 = pc + 32'd4;

    always_comb begin
        // NOTE: npc gets a default before any branch of the if, so every path
        // assigns it and no latch can be inferred.
        npc = pcPlus4;
        if (jump) begin
            // Jump stays inside the 256 MB region of the sequential PC.
            npc = {pcPlus4[31:28], instr[25:0], 2'b00};
        end else if (branch && zero) begin
            npc = pcPlus4 + branchOffset(instr[15:0]);
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
// Two-state instruction fetch: FETCH requests the word at pc from
// instruction memory; HOLD presents the latched word to decode/execute until
// it is consumed, at which point the PC advances to npc.
//
// Parameter
//   RESET_PC          : PC loaded on reset (word aligned)
// Ports
//   clk               in   1 : clock, rising edge
//   rst               in   1 : asynchronous, active-high reset
//   imem_req          out  1 : read request (FETCH, not in reset)
//   imem_addr         out 32 : fetch byte address, always equal to pc
//   imem_ack          in   1 : imem_rdata valid this cycle (used only in FETCH)
//   imem_rdata        in  32 : fetched instruction
//   instr_valid       out  1 : instr/op/func/pc hold a valid instruction
//   instr_ready       in   1 : downstream consumes the instruction
//   instr             out 32 : latched instruction
//   op, func          out  6 : instr[31:26] and instr[5:0]
//   branch/jump/zero  in   1 : next-PC controls, sampled only on consume
//   pc                out 32 : address of the instruction in instr
//   retired_cnt       out 32 : consumed-instruction count (optional)
//
// Build option
//   IFETCH_RETIRE_CNT_EN : when defined, adds retired_cnt, a wrapping count
//                          of consumed instructions.
// ---------------------------------------------------------------------------
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  func,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] pc
`ifdef IFETCH_RETIRE_CNT_EN
    ,
    output logic [31:0] retired_cnt
`endif
);

    fetchState_t state;
    logic [31:0] pcReg;
    logic [31:0] instrReg;
    logic [31:0] npc;
    logic        consume;

    assign consume = (state == HOLD) && instr_ready;

    npc_calc uNpcCalc (
        .pc     (pcReg),
        .instr  (instrReg),
        .branch (branch),
        .jump   (jump),
        .zero   (zero),
        .npc    (npc)
    );

    // Single FSM process; the PC and instruction registers are its outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state    <= FETCH;
            pcReg    <= {RESET_PC[31:2], 2'b00};
            instrReg <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        instrReg <= imem_rdata;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    // An ack seen here is stale and is deliberately ignored.
                    if (consume) begin
                        pcReg <= npc;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

`ifdef IFETCH_RETIRE_CNT_EN
    logic [31:0] retiredReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retiredReg <= '0;
        end else if (consume) begin
            retiredReg <= retiredReg + 32'd1;
        end
    end

    assign retired_cnt = retiredReg;
`endif

    // The reset term keeps the request low while reset is held, even though
    // the state register already sits in FETCH.
    assign imem_req    = (state == FETCH) && !rst;
    assign instr_valid = (state == HOLD);
    assign imem_addr   = pcReg;
    assign pc          = pcReg;
    assign instr       = instrReg;
    assign op          = instrReg[31:26];
    assign func        = instrReg[5:0];

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit
// Bench for ifetch_unit. A transaction-level reference (one instruction in
// flight: either awaiting memory or awaiting consume) predicts every output
// each cycle; directed sequences pin that reference with literal values.
// A second instance with a high RESET_PC exercises the jump region rule.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ifetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] HI_RESET_PC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_ready;
    logic        branch;
    logic        jump;
    logic        zero;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [31:0] pc;

    logic        hiReq;
    logic [31:0] hiAddr;
    logic        hiValid;
    logic [31:0] hiInstr;
    logic [5:0]  hiOp;
    logic [5:0]  hiFunc;
    logic [31:0] hiPc;

`ifdef IFETCH_RETIRE_CNT_EN
    logic [31:0] retired_cnt;
    logic [31:0] hiRetired;
`endif

    int nChecks = 0;
    int nFails  = 0;

    ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .op          (op),
        .func        (func),
        .branch      (branch),
        .jump        (jump),
        .zero        (zero),
        .pc          (pc)
`ifdef IFETCH_RETIRE_CNT_EN
        ,
        .retired_cnt (retired_cnt)
`endif
    );

    ifetch_unit #(.RESET_PC(HI_RESET_PC)) dutHi (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (hiReq),
        .imem_addr   (hiAddr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (hiValid),
        .instr_ready (instr_ready),
        .instr       (hiInstr),
        .op          (hiOp),
        .func        (hiFunc),
        .branch      (branch),
        .jump        (jump),
        .zero        (zero),
        .pc          (hiPc)
`ifdef IFETCH_RETIRE_CNT_EN
        ,
        .retired_cnt (hiRetired)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Next address from the architectural rules, in plain arithmetic.
    function automatic logic [31:0] refNpc(input logic [31:0] pcv, input logic [31:0] iw,
                                           input logic b, input logic j, input logic z);
        logic [31:0] seq;
        int          off;
        seq = pcv + 32'd4;
        if (j) return (seq & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) << 2);
        if (b && z) begin
            off = 4 * int'($signed(iw[15:0]));
            return seq + 32'(off);
        end
        return seq;
    endfunction

    // Reference: one instruction slot, either empty (awaiting memory) or full.
    logic [31:0] mPc      = 32'h0;
    logic [31:0] mInstr   = 32'h0;
    logic        mValid   = 1'b0;
    logic [31:0] mRetired = 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPc      = 32'h0;
            mInstr   = 32'h0;
            mValid   = 1'b0;
            mRetired = 32'h0;
        end else if (!mValid && imem_ack) begin
            mInstr = imem_rdata;
            mValid = 1'b1;
        end else if (mValid && instr_ready) begin
            mPc      = refNpc(mPc, mInstr, branch, jump, zero);
            mValid   = 1'b0;
            mRetired = mRetired + 32'd1;
        end
    end

    // Compare process: every cycle, shortly after inputs change at negedge.
    always @(negedge clk) begin
        #1;
        check("cmp_req",   {31'b0, imem_req},    {31'b0, (!mValid && !rst)});
        check("cmp_valid", {31'b0, instr_valid}, {31'b0, mValid});
        check("cmp_addr",  imem_addr, mPc);
        check("cmp_pc",    pc, mPc);
        check("cmp_instr", instr, mInstr);
        check("cmp_op",    {26'b0, op},   mInstr >> 26);
        check("cmp_func",  {26'b0, func}, mInstr & 32'h3F);
`ifdef IFETCH_RETIRE_CNT_EN
        check("cmp_retired", retired_cnt, mRetired);
`endif
    end

    function automatic logic [31:0] randWord();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 3))
            0:       return {OP_BEQ, r[25:0]};
            1:       return {OP_J, r[25:0]};
            default: return r;
        endcase
    endfunction

    task automatic doReset(input logic [31:0] expPc);
        rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0;
        branch = 1'b0; jump = 1'b0; zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req",   {31'b0, imem_req},    32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_pc",    pc, expPc);
        check("rst_instr", instr, 32'h0);
        check("rst_hi_pc", hiPc, HI_RESET_PC);
`ifdef IFETCH_RETIRE_CNT_EN
        check("rst_retired", retired_cnt, 32'h0);
`endif
        rst = 1'b0;
        #1;
        check("rel_req",  {31'b0, imem_req}, 32'h1);
        check("rel_addr", imem_addr, expPc);
    endtask

    // Serve one fetch after `waits` cycles without ack.
    task automatic fetchWord(input logic [31:0] word, input int waits, input logic [31:0] expAddr);
        for (int i = 0; i < waits; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            check("wait_addr", imem_addr, expAddr);
            check("wait_req",  {31'b0, imem_req}, 32'h1);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom();
        check("ack_valid", {31'b0, instr_valid}, 32'h1);
        check("ack_instr", instr, word);
        check("ack_addr",  imem_addr, expAddr);
    endtask

    // Hold the instruction `holds` cycles, then consume with the given controls.
    task automatic consumeWith(input logic b, input logic j, input logic z, input int holds,
                               input logic [31:0] expPc, input logic [31:0] expNpc);
        for (int i = 0; i < holds; i++) begin
            instr_ready = 1'b0;
            branch = 1'($urandom()); jump = 1'($urandom()); zero = 1'($urandom());
            imem_ack = 1'($urandom());
            @(negedge clk);
            check("hold_valid", {31'b0, instr_valid}, 32'h1);
            check("hold_pc",    pc, expPc);
        end
        imem_ack = 1'b0;
        instr_ready = 1'b1; branch = b; jump = j; zero = z;
        @(negedge clk);
        instr_ready = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0;
        check("cons_valid", {31'b0, instr_valid}, 32'h0);
        check("cons_pc",    pc, expNpc);
        check("cons_addr",  imem_addr, expNpc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
        branch = 1'b0; jump = 1'b0; zero = 1'b0;

        // Reset, zero-wait fetch and consume.
        doReset(32'h0);
        fetchWord(32'h0000_0020, 0, 32'h0);
        consumeWith(1'b0, 1'b0, 1'b0, 0, 32'h0, 32'h4);

        // Wait states and backpressure.
        fetchWord(32'h0123_4567, 3, 32'h4);
        consumeWith(1'b0, 1'b0, 1'b0, 4, 32'h4, 32'h8);
        check("bp_instr", instr, 32'h0123_4567);

        // Branch taken / not taken from pc=0x10.
        fetchWord(32'h0, 0, 32'h8);
        consumeWith(1'b0, 1'b0, 1'b0, 0, 32'h8, 32'hC);
        fetchWord(32'h0, 0, 32'hC);
        consumeWith(1'b0, 1'b0, 1'b0, 0, 32'hC, 32'h10);
        fetchWord(32'h1000_FFFE, 0, 32'h10);
        consumeWith(1'b1, 1'b0, 1'b1, 1, 32'h10, 32'h0C);
        fetchWord(32'h0, 0, 32'hC);
        consumeWith(1'b0, 1'b0, 1'b0, 0, 32'hC, 32'h10);
        fetchWord(32'h1000_FFFE, 2, 32'h10);
        consumeWith(1'b1, 1'b0, 1'b0, 0, 32'h10, 32'h14);

        // Jump priority; high-PC instance lands in its own region.
        doReset(32'h0);
        fetchWord(32'h0800_0004, 0, 32'h0);
        consumeWith(1'b1, 1'b1, 1'b1, 0, 32'h0, 32'h10);
        check("jump_hi_pc", hiPc, 32'h8000_0010);

        // Backward branch from 0 wraps to 0xFFFFFFFC; sequential wraps to 0.
        doReset(32'h0);
        fetchWord(32'h1000_FFFE, 0, 32'h0);
        consumeWith(1'b1, 1'b0, 1'b1, 0, 32'h0, 32'hFFFF_FFFC);
        fetchWord(32'h0, 1, 32'hFFFF_FFFC);
        consumeWith(1'b0, 1'b0, 1'b0, 0, 32'hFFFF_FFFC, 32'h0);
        fetchWord(32'h0, 0, 32'h0);
        consumeWith(1'b0, 1'b0, 1'b0, 0, 32'h0, 32'h4);

        // Reset while waiting for ack, with an ack arriving during reset.
        imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("midrst_pc",  pc, 32'h0);
        check("midrst_req", {31'b0, imem_req}, 32'h0);
        @(negedge clk);
        check("midrst_valid", {31'b0, instr_valid}, 32'h0);
        check("midrst_instr", instr, 32'h0);
        rst = 1'b0; imem_ack = 1'b0;
        @(negedge clk);
        check("postrst_valid", {31'b0, instr_valid}, 32'h0);
        check("postrst_addr",  imem_addr, 32'h0);

`ifdef IFETCH_RETIRE_CNT_EN
        // Five consumes, then reset clears the count.
        doReset(32'h0);
        for (int i = 0; i < 5; i++) begin
            fetchWord(randWord(), i % 2, 32'(4 * i));
            consumeWith(1'b0, 1'b0, 1'b0, i % 3, 32'(4 * i), 32'(4 * i + 4));
        end
        check("cnt_five", retired_cnt, 32'd5);
        doReset(32'h0);
        check("cnt_cleared", retired_cnt, 32'd0);
`endif

        // Randomized traffic checked by the compare process.
        doReset(32'h0);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            imem_ack    = ($urandom_range(0, 2) == 0);
            imem_rdata  = randWord();
            instr_ready = 1'($urandom());
            branch      = 1'($urandom());
            jump        = ($urandom_range(0, 3) == 0);
            zero        = 1'($urandom());
            rst         = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
